// File: rtl/rvx10_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rvx10_mem_pkg
// Brief    : Shared types for the RVX10 unified-memory port arbiter.
// Revision : 1.0
// ============================================================================
package rvx10_mem_pkg;

  localparam int WMASK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter32.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter32
// Brief    : 32-bit enabled up-counter, saturating at all-ones, async clear.
// Revision : 1.0
// ============================================================================
module sat_counter32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port memory between IF fetches and MEM
//            loads/stores, one outstanding transaction at a time.
//            Optional performance counters: MEM_ARB_PERF_EN.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
  import rvx10_mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic [XLEN-1:0]    if_rdata,
  output logic               if_valid,
  input  logic               dm_re,
  input  logic               dm_we,
  input  logic [ADDR_W-1:0]  dm_addr,
  input  logic [XLEN-1:0]    dm_wdata,
  input  logic [WMASK_W-1:0] dm_wmask,
  output logic [XLEN-1:0]    dm_rdata,
  output logic               dm_done,
  input  logic               flush_f,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  output logic [WMASK_W-1:0] mem_wmask,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               stall_if,
  output logic               stall_mem,
  output logic [31:0]        perf_if_wait,
  output logic [31:0]        perf_dm_block
);

  arb_state_t         state_q,    state_d;
  owner_t             owner_q,    owner_d;
  logic               discard_q,  discard_d;
  logic               we_q,       we_d;
  logic [ADDR_W-1:0]  addr_q,     addr_d;
  logic [XLEN-1:0]    wdata_q,    wdata_d;
  logic [WMASK_W-1:0] wmask_q,    wmask_d;
  logic [XLEN-1:0]    if_rdata_q, if_rdata_d;
  logic               if_valid_q, if_valid_d;
  logic [XLEN-1:0]    dm_rdata_q, dm_rdata_d;
  logic               dm_done_q,  dm_done_d;

  // A requester whose completion pulse is showing this cycle is not pending,
  // so the IDLE turnaround never re-issues the access that just finished.
  logic w_dm_pend;
  logic w_if_pend;
  assign w_dm_pend = (dm_re | dm_we) & ~dm_done_q;
  assign w_if_pend = if_req & ~if_valid_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    discard_d  = discard_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if_rdata_d = if_rdata_q;
    if_valid_d = 1'b0;
    dm_rdata_d = dm_rdata_q;
    dm_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_dm_pend) begin
          state_d = REQ;
          owner_d = OWN_DM;
          we_d    = dm_we;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          wmask_d = dm_wmask;
        end else if (w_if_pend) begin
          state_d = REQ;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
          wmask_d = '1;
        end
      end
      REQ: begin
        if ((owner_q == OWN_IF) && flush_f) discard_d = 1'b1;
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          we_d    = 1'b0;
          if (owner_q == OWN_DM) begin
            dm_done_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata;
          end else begin
            discard_d = 1'b0;
            // A flush arriving together with the response still kills it.
            if (!(discard_q || flush_f)) begin
              if_valid_d = 1'b1;
              if_rdata_d = mem_rdata;
            end
          end
        end else if ((owner_q == OWN_IF) && flush_f) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      discard_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_rdata_q <= '0;
      dm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      discard_q  <= discard_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      if_rdata_q <= if_rdata_d;
      if_valid_q <= if_valid_d;
      dm_rdata_q <= dm_rdata_d;
      dm_done_q  <= dm_done_d;
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_done   = dm_done_q;
  assign stall_if  = w_if_pend;
  assign stall_mem = w_dm_pend;

`ifdef MEM_ARB_PERF_EN
  logic w_dm_block;
  assign w_dm_block = if_req & (owner_q == OWN_DM) & (state_q != IDLE);

  sat_counter32 u_if_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (stall_if),
    .count_o (perf_if_wait)
  );

  sat_counter32 u_dm_block (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (w_dm_block),
    .count_o (perf_dm_block)
  );
`else
  assign perf_if_wait  = '0;
  assign perf_dm_block = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_re;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wmask;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        flush_f;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic [31:0] perf_if_wait;
  logic [31:0] perf_dm_block;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .ADDR_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_rdata      (if_rdata),
    .if_valid      (if_valid),
    .dm_re         (dm_re),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_wmask      (dm_wmask),
    .dm_rdata      (dm_rdata),
    .dm_done       (dm_done),
    .flush_f       (flush_f),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .stall_if      (stall_if),
    .stall_mem     (stall_mem),
    .perf_if_wait  (perf_if_wait),
    .perf_dm_block (perf_dm_block)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_re = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_wmask = '0; flush_f = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_dm_done", {31'd0, dm_done}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_perf_if", perf_if_wait, 32'd0);
    chk("rst_perf_dm", perf_dm_block, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", {31'd0, mem_req}, 32'd0);

    // 1: plain fetch
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk("t1_stall_n", {31'd0, stall_if}, 32'd1);
    @(negedge clk);
    chk("t1_req", {31'd0, mem_req}, 32'd1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_we", {31'd0, mem_we}, 32'd0);
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("t1_wait_req", {31'd0, mem_req}, 32'd0);
    chk("t1_stall_n2", {31'd0, stall_if}, 32'd1);
    chk("t1_valid_early", {31'd0, if_valid}, 32'd0);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00A0_0093;
    @(negedge clk);
    chk("t1_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_rdata", if_rdata, 32'h00A0_0093);
    chk("t1_stall_off", {31'd0, stall_if}, 32'd0);
    mem_rvalid = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("t1_valid_pulse", {31'd0, if_valid}, 32'd0);
    chk("t1_idle", {31'd0, mem_req}, 32'd0);

    // 2: simultaneous IF and DM load, DM first; flush must not touch DM
    if_req = 1'b1; if_addr = 32'h104; dm_re = 1'b1; dm_addr = 32'h2000;
    @(negedge clk);
    chk("t2_dm_req", {31'd0, mem_req}, 32'd1);
    chk("t2_dm_addr", mem_addr, 32'h2000);
    chk("t2_stall_mem", {31'd0, stall_mem}, 32'd1);
    chk("t2_stall_if1", {31'd0, stall_if}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; flush_f = 1'b1;
    @(negedge clk);
    chk("t2_dm_done", {31'd0, dm_done}, 32'd1);
    chk("t2_dm_rdata", dm_rdata, 32'h1234_5678);
    chk("t2_stall_mem_off", {31'd0, stall_mem}, 32'd0);
    chk("t2_turnaround", {31'd0, mem_req}, 32'd0);
    chk("t2_stall_if2", {31'd0, stall_if}, 32'd1);
    mem_rvalid = 1'b0; dm_re = 1'b0; flush_f = 1'b0;
    @(negedge clk);
    chk("t2_if_req", {31'd0, mem_req}, 32'd1);
    chk("t2_if_addr", mem_addr, 32'h104);
    chk("t2_dm_done_pulse", {31'd0, dm_done}, 32'd0);
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("t2_stall_if3", {31'd0, stall_if}, 32'd1);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("t2_if_valid", {31'd0, if_valid}, 32'd1);
    chk("t2_if_rdata", if_rdata, 32'h0000_0013);
`ifdef MEM_ARB_PERF_EN
    chk("t2_perf_if", perf_if_wait, 32'd9);
    chk("t2_perf_dm", perf_dm_block, 32'd2);
`else
    chk("t2_perf_if_off", perf_if_wait, 32'd0);
    chk("t2_perf_dm_off", perf_dm_block, 32'd0);
`endif
    mem_rvalid = 1'b0; if_req = 1'b0;
    @(negedge clk);

    // 3: store with gnt delayed three cycles; fields held while requester changes
    dm_we = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF; dm_wmask = 4'b0011;
    @(negedge clk);
    dm_wdata = 32'h0; dm_addr = 32'h0; dm_wmask = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      chk("t3_req", {31'd0, mem_req}, 32'd1);
      chk("t3_we", {31'd0, mem_we}, 32'd1);
      chk("t3_addr", mem_addr, 32'h2004);
      chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t3_wmask", {28'd0, mem_wmask}, 32'h3);
      if (i == 2) mem_gnt = 1'b1;
      @(negedge clk);
    end
    chk("t3_wait_req", {31'd0, mem_req}, 32'd0);
    chk("t3_no_done", {31'd0, dm_done}, 32'd0);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t3_done", {31'd0, dm_done}, 32'd1);
    chk("t3_rdata_kept", dm_rdata, 32'h1234_5678);
    chk("t3_stall_off", {31'd0, stall_mem}, 32'd0);
    chk("t3_we_clear", {31'd0, mem_we}, 32'd0);
    mem_rvalid = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    chk("t3_done_pulse", {31'd0, dm_done}, 32'd0);

    // 4: fetch flushed in WAIT, then a fresh fetch
    if_req = 1'b1; if_addr = 32'h180;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; flush_f = 1'b1;
    @(negedge clk);
    flush_f = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    chk("t4_killed", {31'd0, if_valid}, 32'd0);
    chk("t4_rdata_kept", if_rdata, 32'h0000_0013);
    mem_rvalid = 1'b0; if_addr = 32'h200;
    @(negedge clk);
    chk("t4_new_req", {31'd0, mem_req}, 32'd1);
    chk("t4_new_addr", mem_addr, 32'h200);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0293;
    @(negedge clk);
    chk("t4_valid", {31'd0, if_valid}, 32'd1);
    chk("t4_rdata", if_rdata, 32'h0000_0293);
    mem_rvalid = 1'b0; if_req = 1'b0;
    @(negedge clk);

    // 5: asynchronous reset during WAIT
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    reset_n = 1'b0; if_req = 1'b0;
    #1;
    chk("t5_if_rdata", if_rdata, 32'd0);
    chk("t5_dm_rdata", dm_rdata, 32'd0);
    chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t5_perf_if", perf_if_wait, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_idle", {31'd0, mem_req}, 32'd0);
    if_req = 1'b1; if_addr = 32'h304;
    @(negedge clk);
    chk("t5_req", {31'd0, mem_req}, 32'd1);
    chk("t5_addr", mem_addr, 32'h304);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0073;
    @(negedge clk);
    chk("t5_valid", {31'd0, if_valid}, 32'd1);
    chk("t5_rdata", if_rdata, 32'h0010_0073);
    mem_rvalid = 1'b0; if_req = 1'b0;
    @(negedge clk);

`ifdef MEM_ARB_PERF_EN
    // 6: counter saturation
    force dut.u_if_wait.count_q = 32'hFFFF_FFFE;
    if_req = 1'b1; if_addr = 32'h400;
    #1 release dut.u_if_wait.count_q;
    @(negedge clk);
    chk("t6_sat1", perf_if_wait, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("t6_sat2", perf_if_wait, 32'hFFFF_FFFF);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0001;
    @(negedge clk);
    chk("t6_valid", {31'd0, if_valid}, 32'd1);
    chk("t6_sat3", perf_if_wait, 32'hFFFF_FFFF);
    mem_rvalid = 1'b0; if_req = 1'b0;
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
